spi_mem_master: RTL and testbench
=================================

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

Purpose: single-lane SPI master that drives the chip's SPI slave memory-access port. It issues memory writes (command 0x02) and memory reads (command 0x0B) from a valid/ready request interface.

Interface
- REQ-001 Parameter CLK_DIV, default 2: SCK half-period in clk cycles; legal range 1..255.
- REQ-002 Parameter DUMMY_CYCLES, default 32: dummy SCK cycles between address and read data; legal range 0..63.
- REQ-003 clk  input  1: single clock; all logic on rising edge.
- REQ-004 rst  input  1: synchronous, active-high reset.
- REQ-005 req_valid_i  input  1: request present.
- REQ-006 req_ready_o  output  1: block can accept a request.
- REQ-007 req_we_i  input  1: 1 = write, 0 = read.
- REQ-008 req_addr_i  input  32: target memory address.
- REQ-009 req_wdata_i  input  32: write data; ignored for reads.
- REQ-010 rsp_valid_o  output  1: one-cycle completion pulse for both writes and reads.
- REQ-011 rsp_rdata_o  output  32: read data; held until the next read completes.
- REQ-012 busy_o  output  1: transaction in progress.
- REQ-013 spi_clk_o  output  1: SCK, mode 0 (idles low).
- REQ-014 spi_csn_o  output  1: chip select, active low.
- REQ-015 spi_sdo_o  output  1: master-out data, MSB first.
- REQ-016 spi_sdi_i  input  1: master-in data.

Function
- REQ-017 The block SHALL accept a request on a rising edge where req_valid_i & req_ready_o are both 1, and SHALL register req_we_i, req_addr_i and req_wdata_i on that edge.
- REQ-018 req_ready_o SHALL be 1 only in IDLE; busy_o SHALL equal ~req_ready_o.
- REQ-019 The FSM states SHALL be IDLE -> SETUP -> SHIFT_OUT -> (read only) DUMMY -> READ_IN -> HOLD -> GAP -> IDLE.
- REQ-020 A write SHALL skip DUMMY and READ_IN: SHIFT_OUT -> HOLD.
- REQ-021 spi_csn_o SHALL go low in the cycle after acceptance and stay low through SETUP, SHIFT_OUT, DUMMY, READ_IN and HOLD.
- REQ-022 spi_csn_o SHALL be high in GAP and IDLE.
- REQ-023 SETUP, HOLD and GAP SHALL each last exactly CLK_DIV cycles, with SCK low throughout.
- REQ-024 Each bit period SHALL be 2*CLK_DIV cycles: SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
- REQ-025 spi_sdo_o SHALL change only while SCK is low: at SETUP entry for bit 0, then on each SCK falling edge.
- REQ-026 spi_sdi_i SHALL be sampled on the clk edge at which SCK rises.
- REQ-027 SHIFT_OUT bit order:
  - write: 0x02, then addr[31:0], then wdata[31:0], 72 bits;
  - read: 0x0B, then addr[31:0], 40 bits.
  - All fields are sent MSB first.
- REQ-028 DUMMY SHALL issue exactly DUMMY_CYCLES SCK pulses with spi_sdo_o = 0; DUMMY_CYCLES = 0 goes straight to READ_IN.
- REQ-029 READ_IN SHALL issue 32 SCK pulses and shift spi_sdi_i MSB first into a 32-bit shift register; spi_sdo_o = 0.
- REQ-030 rsp_valid_o SHALL pulse for one cycle on the GAP -> IDLE transition, in the same cycle req_ready_o returns high.
- REQ-031 For reads, rsp_rdata_o SHALL be updated with the shifted word in the same cycle as the rsp_valid_o pulse.
- REQ-032 Latency: rsp_valid_o SHALL assert exactly 3*CLK_DIV + 2*CLK_DIV*N + 1 cycles after the acceptance edge.
  - N = 72 for a write.
  - N = 72 + DUMMY_CYCLES for a read.
- REQ-033 Counters SHALL be sized for the maximums: bit counter 0..135, divider 0..254.
- REQ-034 The bit counter SHALL never wrap mid-field.
- REQ-035 req_valid_i asserted while busy SHALL be ignored and not queued; requests are back-to-back only via IDLE.
- REQ-036 Input changes on req_* after acceptance SHALL NOT affect the transaction in flight.

Reset
- REQ-037 While rst = 1, on the next edge: state = IDLE, req_ready_o = 1, busy_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, spi_clk_o = 0, spi_csn_o = 1, spi_sdo_o = 0.
- REQ-038 Reset mid-transaction SHALL abort immediately with no rsp_valid_o pulse; the next request after reset SHALL run normally.

Verification
- REQ-039 Write, CLK_DIV=2, addr 0x1A10_0000, data 0xDEADBEEF -> the slave model captures 72 bits: 0x02, 0x1A100000, 0xDEADBEEF; rsp_valid_o pulses 295 cycles after acceptance.
- REQ-040 Read, CLK_DIV=2, DUMMY_CYCLES=32, slave returns 0x12345678 -> SDO carries 0x0B and the address, then 32 zero bits; rsp_rdata_o = 0x12345678 with a one-cycle rsp_valid_o.
- REQ-041 CLK_DIV=1 write -> SCK toggles every cycle, every bit period is 2 cycles, and the captured data is correct.
- REQ-042 Assert rst after 20 SCK pulses of a write -> the next cycle has spi_csn_o = 1, spi_clk_o = 0, no rsp_valid_o; a following read completes correctly.
- REQ-043 req_valid_i held high continuously for two requests -> the second is accepted only on the rsp_valid_o cycle; spi_csn_o is high for at least CLK_DIV cycles between the two frames.
- REQ-044 DUMMY_CYCLES=0 read -> READ_IN begins directly after the last address bit; the read word is correct.

Source files
------------

// File: rtl/spi_mem_master.sv
// Single-lane SPI mode-0 master for the on-chip memory-access slave.
// Issues 0x02 writes and 0x0B reads framed as SETUP, shift, optional dummy/read, HOLD and GAP.
module spi_mem_master #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        busy_o,
  output logic        spi_clk_o,
  output logic        spi_csn_o,
  output logic        spi_sdo_o,
  input  logic        spi_sdi_i
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SETUP     = 3'd1;
  localparam logic [2:0] S_SHIFT_OUT = 3'd2;
  localparam logic [2:0] S_DUMMY     = 3'd3;
  localparam logic [2:0] S_READ_IN   = 3'd4;
  localparam logic [2:0] S_HOLD      = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;

  localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0] WR_LAST    = 8'd71;
  localparam logic [7:0] RD_LAST    = 8'd39;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
  localparam logic [7:0] DATA_LAST  = 8'd31;
  localparam logic [2:0] RD_AFTER_ADDR = (DUMMY_CYCLES == 0) ? S_READ_IN : S_DUMMY;

  logic [2:0]  r_state;
  logic [7:0]  r_div;
  logic [7:0]  r_bit_cnt;
  logic        r_we;
  logic [70:0] r_tx;
  logic [31:0] r_rx;
  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_rsp_valid;
  logic        r_sck;
  logic        r_csn;
  logic        r_sdo;

  logic        w_accept;
  logic        w_half_done;
  logic        w_bit_last;
  logic [7:0]  w_field_last;
  logic [2:0]  w_next;
  logic [71:0] w_frame;

  // Field length, successor state and outgoing frame for the current request
  always_comb begin
    w_accept     = req_valid_i & r_ready;
    w_half_done  = (r_div == DIV_LAST);
    w_frame      = req_we_i ? {8'h02, req_addr_i, req_wdata_i}
                            : {8'h0B, req_addr_i, 32'h0000_0000};
    w_field_last = 8'd0;
    w_next       = S_IDLE;
    case (r_state)
      S_SETUP:     w_next = S_SHIFT_OUT;
      S_SHIFT_OUT: begin
        w_field_last = r_we ? WR_LAST : RD_LAST;
        w_next       = r_we ? S_HOLD : RD_AFTER_ADDR;
      end
      S_DUMMY: begin
        w_field_last = DUMMY_LAST;
        w_next       = S_READ_IN;
      end
      S_READ_IN: begin
        w_field_last = DATA_LAST;
        w_next       = S_HOLD;
      end
      S_HOLD:      w_next = S_GAP;
      S_GAP:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    w_bit_last = (r_bit_cnt == w_field_last);
  end

  // Transaction sequencer, SCK divider and data shifters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= 8'd0;
      r_bit_cnt   <= 8'd0;
      r_we        <= 1'b0;
      r_tx        <= 71'd0;
      r_rx        <= 32'd0;
      r_rdata     <= 32'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_sck       <= 1'b0;
      r_csn       <= 1'b1;
      r_sdo       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we      <= req_we_i;
            r_tx      <= w_frame[70:0];
            r_sdo     <= w_frame[71];
            r_csn     <= 1'b0;
            r_ready   <= 1'b0;
            r_div     <= 8'd0;
            r_bit_cnt <= 8'd0;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP, S_HOLD, S_GAP: begin
          if (w_half_done) begin
            r_div   <= 8'd0;
            r_state <= w_next;
            if (r_state == S_HOLD) begin
              r_csn <= 1'b1;
            end
            if (r_state == S_GAP) begin
              r_ready     <= 1'b1;
              r_rsp_valid <= 1'b1;
              if (!r_we) begin
                r_rdata <= r_rx;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        S_SHIFT_OUT, S_DUMMY, S_READ_IN: begin
          if (w_half_done) begin
            r_div <= 8'd0;
            r_sck <= ~r_sck;
            // Rising SCK samples SDI; falling SCK closes the bit and presents the next one
            if (!r_sck) begin
              if (r_state == S_READ_IN) begin
                r_rx <= {r_rx[30:0], spi_sdi_i};
              end
            end else if (w_bit_last) begin
              r_bit_cnt <= 8'd0;
              r_sdo     <= 1'b0;
              r_state   <= w_next;
            end else begin
              r_bit_cnt <= r_bit_cnt + 8'd1;
              if (r_state == S_SHIFT_OUT) begin
                r_sdo <= r_tx[70];
                r_tx  <= {r_tx[69:0], 1'b0};
              end else begin
                r_sdo <= 1'b0;
              end
            end
          end else begin
            r_div <= r_div + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_csn   <= 1'b1;
          r_sck   <= 1'b0;
          r_sdo   <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o = r_ready;
  assign busy_o      = ~r_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign spi_clk_o   = r_sck;
  assign spi_csn_o   = r_csn;
  assign spi_sdo_o   = r_sdo;

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: three instances (CLK_DIV/DUMMY = 2/32, 1/0, 3/5) driven by
// directed and random requests; a cycle-level slave model captures SDO and returns read words.
module tb_spi_mem_master;

  logic        clk;
  logic [2:0]  rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_we;
  logic [2:0]  sdi;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  wire  [2:0]  req_ready;
  wire  [2:0]  rsp_valid;
  wire  [2:0]  busy;
  wire  [2:0]  sck;
  wire  [2:0]  csn;
  wire  [2:0]  sdo;
  wire  [31:0] rsp_rdata [3];

  int          n_cmp;
  int          n_bad;
  logic [31:0] last_rdata [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned GCD = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    localparam int unsigned GDC = (g == 0) ? 32 : ((g == 1) ? 0 : 5);
    spi_mem_master #(.CLK_DIV(GCD), .DUMMY_CYCLES(GDC)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]), .req_we_i(req_we[g]),
      .req_addr_i(req_addr[g]), .req_wdata_i(req_wdata[g]),
      .rsp_valid_o(rsp_valid[g]), .rsp_rdata_o(rsp_rdata[g]), .busy_o(busy[g]),
      .spi_clk_o(sck[g]), .spi_csn_o(csn[g]), .spi_sdo_o(sdo[g]), .spi_sdi_i(sdi[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cd_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic int dc_of(input int g);
    return (g == 0) ? 32 : ((g == 1) ? 0 : 5);
  endfunction

  task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request, wait for acceptance, then act as the slave until the response.
  task automatic run_txn(input int g, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] word,
                         input bit hold, input logic nwe, input logic [31:0] naddr,
                         input logic [31:0] nwdata, input bit immediate);
    int cd, dc, nbits, lat_exp, waited, m, rises, last_rise, rx_idx;
    int bad_period, bad_sdo, bad_busy, csn_hi_run;
    logic [135:0] cap, exp_cap;
    logic prev_sck, prev_sdo;
    bit done;
    cd      = cd_of(g);
    dc      = dc_of(g);
    nbits   = we ? 72 : 72 + dc;
    lat_exp = 3 * cd + 2 * cd * nbits + 1;
    exp_cap = we ? {64'h0, 8'h02, addr, wdata} : ({96'h0, 8'h0B, addr} << (dc + 32));
    if (!we) last_rdata[g] = word;
    req_we[g] = we; req_addr[g] = addr; req_wdata[g] = wdata;
    req_valid[g] = 1'b1; sdi[g] = 1'b0;
    waited = 0; done = 1'b0;
    while (!done && waited < 5000) begin
      @(negedge clk); done = req_ready[g];
      @(posedge clk); waited++;
    end
    check($sformatf("g%0d_accept", g), done, 1);
    if (immediate) check($sformatf("g%0d_accept_on_rsp_cycle", g), waited, 1);
    if (!done) begin
      req_valid[g] = 1'b0;
      return;
    end
    #1;
    if (hold) begin
      req_we[g] = nwe; req_addr[g] = naddr; req_wdata[g] = nwdata;
    end else begin
      req_valid[g] = 1'b0;
      req_we[g] = 1'($urandom); req_addr[g] = $urandom; req_wdata[g] = $urandom;
    end
    check($sformatf("g%0d_csn_low_after_accept", g), csn[g], 0);
    prev_sck = sck[g]; prev_sdo = sdo[g];
    m = 0; rises = 0; last_rise = -1; cap = '0;
    bad_period = 0; bad_sdo = 0; bad_busy = 0; csn_hi_run = 0;
    done = 1'b0;
    while (!done && m < 20000) begin
      @(posedge clk); m++; #1;
      if (busy[g] !== ~req_ready[g]) bad_busy++;
      if (req_ready[g] !== 1'b0 && rsp_valid[g] !== 1'b1) bad_busy++;
      if (sck[g] === 1'b1 && csn[g] === 1'b1) bad_sdo++;
      if (sdo[g] !== prev_sdo && sck[g] !== 1'b0) bad_sdo++;
      if (sck[g] && !prev_sck) begin
        cap = {cap[134:0], sdo[g]};
        if (last_rise >= 0 && m - last_rise != 2 * cd) bad_period++;
        last_rise = m;
        rises++;
      end
      if (!sck[g] && prev_sck) begin
        rx_idx = rises - (40 + dc);
        sdi[g] = (!we && rx_idx >= 0 && rx_idx < 32) ? word[31 - rx_idx] : 1'b0;
      end
      csn_hi_run = csn[g] ? csn_hi_run + 1 : 0;
      prev_sck = sck[g]; prev_sdo = sdo[g];
      if (rsp_valid[g]) done = 1'b1;
    end
    // The cycle that begins at the acceptance edge counts as cycle 1.
    check($sformatf("g%0d_rsp_seen", g), done, 1);
    check($sformatf("g%0d_latency", g), m + 1, lat_exp);
    check($sformatf("g%0d_frame_bits", g), rises, nbits);
    check($sformatf("g%0d_frame_data", g), cap, exp_cap);
    check($sformatf("g%0d_sck_period", g), bad_period, 0);
    check($sformatf("g%0d_sdo_sck_rules", g), bad_sdo, 0);
    check($sformatf("g%0d_ready_busy", g), bad_busy, 0);
    // GAP keeps CS high for CLK_DIV cycles, plus the response cycle itself.
    check($sformatf("g%0d_gap_csn_high", g), csn_hi_run, cd + 1);
    check($sformatf("g%0d_ready_at_rsp", g), req_ready[g], 1);
    check($sformatf("g%0d_rdata", g), rsp_rdata[g], last_rdata[g]);
    if (!hold) begin
      @(posedge clk); #1;
      check($sformatf("g%0d_rsp_one_cycle", g), rsp_valid[g], 0);
    end
  endtask

  // Start a write, pull reset after 20 SCK pulses, and confirm the abort is silent.
  task automatic reset_mid(input int g);
    int waited, m, rises, bad;
    logic prev_sck;
    bit done;
    req_we[g] = 1'b1; req_addr[g] = $urandom; req_wdata[g] = $urandom; req_valid[g] = 1'b1;
    waited = 0; done = 1'b0;
    while (!done && waited < 5000) begin
      @(negedge clk); done = req_ready[g];
      @(posedge clk); waited++;
    end
    #1; req_valid[g] = 1'b0;
    check("rst_accept", done, 1);
    prev_sck = sck[g]; rises = 0; m = 0;
    while (rises < 20 && m < 5000) begin
      @(posedge clk); m++; #1;
      if (sck[g] && !prev_sck) rises++;
      prev_sck = sck[g];
    end
    check("rst_reach_20_pulses", rises, 20);
    rst[g] = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_ctl", {csn[g], sck[g], rsp_valid[g], req_ready[g], busy[g], sdo[g]}, 6'b100100);
    check("rst_abort_rdata", rsp_rdata[g], 32'h0);
    last_rdata[g] = 32'h0;
    rst[g] = 1'b0;
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (rsp_valid[g] !== 1'b0 || csn[g] !== 1'b1) bad++;
    end
    check("rst_no_rsp_after_abort", bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [31:0] a, d, w;
    n_cmp = 0; n_bad = 0;
    rst = 3'b111; req_valid = 3'b000; req_we = 3'b000; sdi = 3'b000;
    for (int i = 0; i < 3; i++) begin
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0; last_rdata[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("g%0d_reset_ctl", i),
            {req_ready[i], busy[i], rsp_valid[i], sck[i], csn[i], sdo[i]}, 6'b100010);
      check($sformatf("g%0d_reset_rdata", i), rsp_rdata[i], 32'h0);
    end
    rst = 3'b000;
    @(posedge clk); #1;

    run_txn(0, 1'b1, 32'h1A10_0000, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h1A10_0040, 32'h0, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(1, 1'b1, 32'hC0FF_EE00, 32'hA5A5_5A5A, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h8000_0001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Valid held high across two requests: second accepted on the response cycle.
    run_txn(0, 1'b1, 32'h2000_0000, 32'h0BAD_F00D, 32'h0, 1'b1, 1'b0, 32'h2000_0004, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h2000_0004, 32'h0, 32'hFEDC_BA98, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    reset_mid(0);
    run_txn(0, 1'b0, 32'h3000_0010, 32'h0, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom; w = $urandom;
      run_txn(i % 3, we, a, d, w, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
